// File: rtl/i2c_step_engine_pkg.sv
// i2c_step_engine_pkg: step codes shared by the I2C step engine and its next-state logic.
package i2c_step_engine_pkg;
    localparam int STEP_W = 4;
    typedef enum logic [STEP_W-1:0] {
        RESET = 4'd0,
        START = 4'd1,
        SENDA = 4'd2,
        ACK_1 = 4'd3,
        SEND1 = 4'd4,
        STOPC = 4'd5
    } step_t;
    function automatic logic is_byte(logic [STEP_W-1:0] s);
        return s == SENDA || s == SEND1;
    endfunction
endpackage

// File: rtl/i2c_step_engine_if.sv
// i2c_step_engine_if: step handshake, request fields and bus pins of the I2C step engine.
interface i2c_step_engine_if;
    import i2c_step_engine_pkg::*;
    logic [STEP_W-1:0] ns;
    logic [STEP_W-1:0] cs;
    logic              nsl_in;
    logic              go;
    logic [6:0]        addr;
    logic              rw;
    logic [7:0]        wdata;
    logic              sda_in;
    logic              scl;
    logic              sda_oe;
    logic              busy;
    logic              ack_err;
    modport master (
        output ns, go, addr, rw, wdata, sda_in,
        input  cs, nsl_in, scl, sda_oe, busy, ack_err
    );
    modport slave (
        input  ns, go, addr, rw, wdata, sda_in,
        output cs, nsl_in, scl, sda_oe, busy, ack_err
    );
endinterface

// File: rtl/i2c_step_engine_qtimer.sv
// i2c_qtimer: clk divider and SCL quarter counter; clear restarts at q0, first clk.
module i2c_qtimer #(
    parameter int CLK_DIV = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    output logic [1:0] q,
    output logic       q_end,
    output logic       q_first
);
    localparam int DW = $clog2(CLK_DIV);
    logic [DW-1:0] div;
    assign q_end   = div == DW'(CLK_DIV - 1);
    assign q_first = div == '0;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div <= '0;
            q   <= '0;
        end else if (clear) begin
            div <= '0;
            q   <= '0;
        end else if (q_end) begin
            div <= '0;
            q   <= q + 2'd1;
        end else begin
            div <= div + DW'(1);
        end
    end
endmodule

// File: rtl/i2c_step_engine.sv
// i2c_step_engine: cs register plus SCL/SDA timing per bus step; cs loads ns on the
// last clk of each step (adv), and nsl_in reports that step's outcome.
module i2c_step_engine
    import i2c_step_engine_pkg::*;
#(
    parameter int CLK_DIV = 250
) (
    input  logic clk,
    input  logic rst,
    i2c_step_engine_if.slave bus
);
    logic [STEP_W-1:0] cs;
    logic [2:0]        bit_cnt;
    logic [7:0]        a_byte;
    logic [7:0]        w_byte;
    logic              sample;
    logic [1:0]        q;
    logic              q_end;
    logic              q_first;
    logic              last_q;
    logic              adv;
    logic              flag;
    logic              scl_c;
    logic              oe_c;
    logic [7:0]        byte_sel;
    logic              cur_bit;

    i2c_qtimer #(.CLK_DIV(CLK_DIV)) u_qtimer (
        .clk    (clk),
        .rst    (rst),
        .clear  (adv | (cs == RESET)),
        .q      (q),
        .q_end  (q_end),
        .q_first(q_first)
    );

    assign last_q   = q_end && q == 2'd3;
    assign byte_sel = cs == SENDA ? a_byte : w_byte;
    assign cur_bit  = byte_sel[3'd7 - bit_cnt];

    always_comb begin
        adv   = 1'b0;
        flag  = 1'b1;
        scl_c = 1'b1;
        oe_c  = 1'b0;
        case (cs)
            RESET: adv = bus.go;
            START: begin
                scl_c = q != 2'd3;
                oe_c  = q[1];
                adv   = last_q;
            end
            SENDA, SEND1: begin
                scl_c = q[1];
                oe_c  = ~cur_bit;
                adv   = last_q && bit_cnt == 3'd7;
            end
            ACK_1: begin
                scl_c = q[1];
                adv   = last_q;
                flag  = ~sample;
            end
            STOPC: begin
                scl_c = q != 2'd0;
                oe_c  = ~q[1];
                adv   = last_q;
            end
            default: begin
                adv  = 1'b1;
                flag = 1'b0;
            end
        endcase
    end

    assign bus.cs      = cs;
    assign bus.scl     = scl_c;
    assign bus.sda_oe  = oe_c;
    assign bus.nsl_in  = adv & flag;
    assign bus.busy    = cs != RESET;
    assign bus.ack_err = adv && cs == ACK_1 && sample;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs      <= RESET;
            bit_cnt <= '0;
            a_byte  <= '0;
            w_byte  <= '0;
            sample  <= 1'b0;
        end else begin
            cs <= adv ? bus.ns : cs;
            bit_cnt <= adv ? 3'd0 : (last_q && is_byte(cs)) ? bit_cnt + 3'd1 : bit_cnt;
            if (cs == RESET && bus.go) begin
                a_byte <= {bus.addr, bus.rw};
                w_byte <= bus.wdata;
            end
            if (cs == ACK_1 && q == 2'd3 && q_first)
                sample <= bus.sda_in;
        end
    end
endmodule

// File: tb/tb_i2c_step_engine.sv
// tb_i2c_step_engine: table of whole transactions with hand-computed cs/flag/bit
// sequences, plus hand sequences for reset and a mid-transfer async reset.
module tb_i2c_step_engine;
    import i2c_step_engine_pkg::*;

    typedef struct {
        logic [6:0]  addr;
        logic        rw;
        logic [7:0]  wdata;
        logic        nack;
        logic        force_f;
        logic [31:0] seq;
        int          n_adv;
        logic [7:0]  nsl;
        logic [15:0] bits;
        int          n_bits;
        int          n_ack;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic nack = 1'b0;
    logic force_f = 1'b0;
    logic mon_en = 1'b0;
    int   errors = 0;
    int   checks = 0;
    vec_t vecs[5];

    logic [3:0] seq_q[$];
    logic       nsl_q[$];
    logic       bits_q[$];
    logic       ack_q[$];

    logic [3:0] p_cs = 4'd0;
    logic       p_nsl = 1'b0;
    logic       p_scl = 1'b1;
    logic       p_oe = 1'b0;
    logic [3:0] run_cs = 4'd0;
    int         run_len = 0;

    i2c_step_engine_if bus();

    i2c_step_engine #(.CLK_DIV(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.sda_in = nack && bus.cs == ACK_1;

    always_comb begin
        bus.ns = RESET;
        case (bus.cs)
            RESET:   bus.ns = START;
            START:   bus.ns = force_f ? 4'hF : SENDA;
            SENDA:   bus.ns = ACK_1;
            ACK_1:   bus.ns = bus.nsl_in ? SEND1 : RESET;
            SEND1:   bus.ns = STOPC;
            STOPC:   bus.ns = RESET;
            default: bus.ns = STOPC;
        endcase
    end

    function automatic bit is_data(logic [3:0] s);
        return s == SENDA || s == ACK_1 || s == SEND1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Adv is inferred from a cs change; the flag seen on the clk before it is the adv flag.
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus.cs != p_cs) begin
                seq_q.push_back(bus.cs);
                nsl_q.push_back(p_nsl);
            end
            if (bus.scl && !p_scl && (bus.cs == SENDA || bus.cs == SEND1))
                bits_q.push_back(~bus.sda_oe);
            if (bus.ack_err)
                ack_q.push_back(1'b1);
            if (p_scl && bus.scl && bus.sda_oe != p_oe)
                chk("sda_edge_while_scl_high",
                    32'((bus.cs == START && bus.sda_oe) || (bus.cs == STOPC && !bus.sda_oe)), 32'd1);
            if (bus.scl != p_scl && is_data(run_cs) && is_data(bus.cs))
                chk("scl_phase_len", run_len, 8);
        end
        run_len <= bus.scl != p_scl ? 1 : run_len + 1;
        run_cs  <= bus.scl != p_scl ? bus.cs : run_cs;
        p_cs    <= bus.cs;
        p_nsl   <= bus.nsl_in;
        p_scl   <= bus.scl;
        p_oe    <= bus.sda_oe;
    end

    task automatic run_vec(input int k);
        logic [3:0]  g;
        logic [15:0] val;
        bit          done;
        g = RESET;
        done = 1'b0;
        @(posedge clk);
        #1;
        bus.addr = vecs[k].addr;
        bus.rw = vecs[k].rw;
        bus.wdata = vecs[k].wdata;
        nack = vecs[k].nack;
        force_f = vecs[k].force_f;
        seq_q.delete();
        nsl_q.delete();
        bits_q.delete();
        ack_q.delete();
        mon_en = 1'b1;
        bus.go = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(posedge clk);
            #1;
            if ((bus.cs == SENDA || bus.cs == SEND1) && g != bus.cs) begin
                g = bus.cs;
                bus.go = 1'b1;
                bus.addr = ~bus.addr;
                bus.wdata = ~bus.wdata;
            end else begin
                bus.go = 1'b0;
            end
            if (c > 0 && !bus.busy) begin
                done = 1'b1;
                break;
            end
        end
        bus.go = 1'b0;
        chk($sformatf("v%0d_done_in_budget", k), 32'(done), 32'd1);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        chk($sformatf("v%0d_adv_count", k), seq_q.size(), vecs[k].n_adv);
        for (int i = 0; i < vecs[k].n_adv; i++) begin
            chk($sformatf("v%0d_cs_%0d", k, i), 32'(seq_q[i]), 32'(vecs[k].seq[31-4*i -: 4]));
            chk($sformatf("v%0d_nsl_%0d", k, i), 32'(nsl_q[i]), 32'(vecs[k].nsl[7-i]));
        end
        val = '0;
        foreach (bits_q[i]) val = {val[14:0], bits_q[i]};
        chk($sformatf("v%0d_bit_count", k), bits_q.size(), vecs[k].n_bits);
        chk($sformatf("v%0d_sda_bits", k), 32'(val), 32'(vecs[k].bits));
        chk($sformatf("v%0d_ack_err_pulses", k), ack_q.size(), vecs[k].n_ack);
        chk($sformatf("v%0d_idle_scl", k), 32'(bus.scl), 32'd1);
        chk($sformatf("v%0d_idle_sda_oe", k), 32'(bus.sda_oe), 32'd0);
        chk($sformatf("v%0d_idle_busy", k), 32'(bus.busy), 32'd0);
    endtask

    initial begin
        bit seen;
        vecs[0] = '{7'h50, 1'b0, 8'hA5, 1'b0, 1'b0, 32'h1234_5000, 6, 8'hFC, 16'hA0A5, 16, 0};
        vecs[1] = '{7'h2B, 1'b1, 8'h3C, 1'b0, 1'b0, 32'h1234_5000, 6, 8'hFC, 16'h573C, 16, 0};
        vecs[2] = '{7'h50, 1'b1, 8'hFF, 1'b1, 1'b0, 32'h1230_0000, 4, 8'hE0, 16'h00A1, 8, 1};
        vecs[3] = '{7'h7F, 1'b1, 8'h00, 1'b0, 1'b1, 32'h1F50_0000, 4, 8'hD0, 16'h0000, 0, 0};
        vecs[4] = '{7'h00, 1'b0, 8'hFF, 1'b0, 1'b0, 32'h1234_5000, 6, 8'hFC, 16'h00FF, 16, 0};
        bus.go = 1'b0;
        bus.addr = 7'h50;
        bus.rw = 1'b0;
        bus.wdata = 8'hA5;
        repeat (3) @(negedge clk);
        chk("rst_cs", 32'(bus.cs), 32'd0);
        chk("rst_scl", 32'(bus.scl), 32'd1);
        chk("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_nsl_in", 32'(bus.nsl_in), 32'd0);
        chk("rst_ack_err", 32'(bus.ack_err), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.go = 1'b1;
        @(posedge clk);
        #1;
        bus.go = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            @(negedge clk);
            seen = bus.cs == SENDA;
        end
        chk("mid_reset_reached_senda", 32'(seen), 32'd1);
        repeat (53) @(negedge clk);
        chk("mid_bit3_scl", 32'(bus.scl), 32'd0);
        chk("mid_bit3_sda_oe", 32'(bus.sda_oe), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_cs", 32'(bus.cs), 32'd0);
        chk("mid_rst_scl", 32'(bus.scl), 32'd1);
        chk("mid_rst_sda_oe", 32'(bus.sda_oe), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("post_rst_idle_cs", 32'(bus.cs), 32'd0);
        for (int k = 0; k < 5; k++) run_vec(k);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
